// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler
//   Takes each completed 10-byte SPI frame and checks its header, sequence and
//   (optionally) checksum. The newest good frame is held as pending. It is
//   committed to the game-state outputs only on the frame tick, so paddle and
//   ball state never change in the middle of a video frame. The block also runs
//   a link watchdog and keeps saturating good/bad frame counters.
//
//   Build option: define FRAME_CHECKSUM_EN to require
//   byte 9 == XOR of bytes 0..8. Without it, byte 9 is ignored.
//
// Ports
//   sys_clk_i      system clock, rising edge
//   rst_i          asynchronous reset, active high
//   frame_i        frame bytes 0..9, stable while frame_ready_i is high
//   frame_ready_i  level, high once the whole frame has been received
//   frame_tick_i   one-cycle pulse at the start of vertical blank
//   payload_o      committed frame bytes 2..8
//   seq_o          committed sequence byte (frame byte 1)
//   commit_o       one-cycle pulse; payload_o/seq_o change in the same cycle
//   link_up_o      a commit happened within the last TIMEOUT_TICKS ticks
//   good_cnt_o     accepted frames, saturating
//   bad_cnt_o      rejected frames (header/checksum), saturating
//
// Capture FSM
//   state     | meaning
//   S_IDLE    | waiting for a rising edge of frame_ready_i
//   S_CAPTURE | copying frame_i into the shadow buffer
//   S_CHECK   | classifying the shadow buffer as bad / duplicate / good
module spi_frame_scheduler #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic [7:0]       frame_i [0:9],
    input  logic             frame_ready_i,
    input  logic             frame_tick_i,
    output logic [7:0]       payload_o [0:6],
    output logic [7:0]       seq_o,
    output logic             commit_o,
    output logic             link_up_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o
);

    localparam int          TW   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_do_capture;
    logic             w_do_check;

    logic             r_ready_q;
    logic [7:0]       r_shadow [0:9];
    logic [7:0]       r_pend [0:7];       // [0] = seq, [1..7] = payload
    logic             r_pend_valid;
    logic             r_seq_valid;
    logic [7:0]       r_last_seq;
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] r_bad_cnt;
    logic [7:0]       r_payload [0:6];
    logic [7:0]       r_seq;
    logic             r_commit;
    logic [TW-1:0]    r_wd_cnt;
    logic             r_link_up;

    logic             w_ready_rise;
    logic             w_hdr_ok;
    logic             w_sum_ok;
    logic             w_good;
    logic             w_dup;
    logic             w_accept;
    logic             w_reject;
    logic             w_commit;
    logic [TW-1:0]    w_wd_nxt;

    assign w_ready_rise = frame_ready_i & ~r_ready_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // A ready edge seen outside S_IDLE is simply not acted on, so that frame is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_ready_rise) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_CHECK;
            S_CHECK:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_do_capture = 1'b0;
        w_do_check   = 1'b0;
        case (r_state)
            S_CAPTURE: w_do_capture = 1'b1;
            S_CHECK:   w_do_check   = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- frame classification ----------------
    assign w_hdr_ok = (r_shadow[0] == SYNC_BYTE);

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] w_xor;
    always_comb begin
        w_xor = 8'h00;
        for (int i = 0; i < 9; i++) w_xor = w_xor ^ r_shadow[i];
    end
    assign w_sum_ok = (w_xor == r_shadow[9]);
`else
    assign w_sum_ok = 1'b1;
`endif

    assign w_good   = w_hdr_ok & w_sum_ok;
    assign w_dup    = w_good & r_seq_valid & (r_shadow[1] == r_last_seq);
    assign w_accept = w_do_check & w_good & ~w_dup;
    assign w_reject = w_do_check & ~w_good;
    assign w_commit = frame_tick_i & r_pend_valid;

    // Watchdog counts ticks since the last commit and stops at TIMEOUT_TICKS.
    always_comb begin
        w_wd_nxt = r_wd_cnt;
        if (w_commit)                              w_wd_nxt = '0;
        else if (frame_tick_i && r_wd_cnt != TMAX) w_wd_nxt = r_wd_cnt + TW'(1);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready_q    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_seq_valid  <= 1'b0;
            r_last_seq   <= 8'h00;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_seq        <= 8'h00;
            r_commit     <= 1'b0;
            r_wd_cnt     <= TMAX;
            r_link_up    <= 1'b0;
            for (int i = 0; i < 10; i++) r_shadow[i]  <= 8'h00;
            for (int i = 0; i < 8;  i++) r_pend[i]    <= 8'h00;
            for (int i = 0; i < 7;  i++) r_payload[i] <= 8'h00;
        end else begin
            r_ready_q <= frame_ready_i;

            if (w_do_capture) begin
                for (int i = 0; i < 10; i++) r_shadow[i] <= frame_i[i];
            end

            if (w_reject && r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + CNT_W'(1);

            if (w_accept) begin
                for (int i = 0; i < 8; i++) r_pend[i] <= r_shadow[i+1];
                r_last_seq  <= r_shadow[1];
                r_seq_valid <= 1'b1;
                if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + CNT_W'(1);
            end

            // A commit reads the old pending entry; a same-cycle accept refills it.
            if (w_accept)      r_pend_valid <= 1'b1;
            else if (w_commit) r_pend_valid <= 1'b0;

            r_commit <= w_commit;
            if (w_commit) begin
                r_seq <= r_pend[0];
                for (int i = 0; i < 7; i++) r_payload[i] <= r_pend[i+1];
            end

            r_wd_cnt  <= w_wd_nxt;
            r_link_up <= (w_wd_nxt != TMAX);
        end
    end

    assign payload_o  = r_payload;
    assign seq_o      = r_seq;
    assign commit_o   = r_commit;
    assign link_up_o  = r_link_up;
    assign good_cnt_o = r_good_cnt;
    assign bad_cnt_o  = r_bad_cnt;

endmodule
